// File: rtl/afifo_rd_packer.sv
// ---------------------------------------------------------------------------
// afifo_rd_packer
//   Read-side consumer of an asynchronous FIFO, living in the clk_rd domain.
//   Bytes are pulled through the FIFO read port (rd_en / empty / rd_data),
//   packed N at a time into one output word with the first byte in lane 0,
//   and presented on a valid/ready master port. A flush pulse forces out
//   whatever has been gathered so far as a partial word with a keep mask.
//
// Parameters
//   N        bytes per output word (2..8)
//   CNT_W    width of the lvl output; must be able to hold the value N
//
// Ports
//   clk_rd   in   1       read-domain clock, all logic on posedge
//   rst      in   1       synchronous active-low reset
//   empty    in   1       FIFO empty flag
//   rd_en    out  1       FIFO read strobe (combinational)
//   rd_data  in   8       FIFO read data, valid the cycle after rd_en
//   flush    in   1       one-cycle request to emit the partial word
//   m_valid  out  1       output word valid
//   m_ready  in   1       downstream accept
//   m_data   out  8*N     packed word, byte k in bits [8k+7:8k]
//   m_keep   out  N       lane k holds a real byte
//   lvl      out  CNT_W   bytes in the accumulator plus any in-flight byte
// ---------------------------------------------------------------------------
module afifo_rd_packer #(
  parameter int N     = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk_rd,
  input  logic             rst,
  input  logic             empty,
  output logic             rd_en,
  input  logic [7:0]       rd_data,
  input  logic             flush,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [8*N-1:0]   m_data,
  output logic [N-1:0]     m_keep,
  output logic [CNT_W-1:0] lvl
);

  typedef enum logic {
    FILL = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_acc_cnt;
  logic             r_rd_pend;
  logic             r_flush_req;
  logic [8*N-1:0]   r_acc;
  logic             r_m_valid;
  logic [8*N-1:0]   r_m_data;
  logic [N-1:0]     r_m_keep;

  logic [CNT_W-1:0] w_lvl;
  logic [N-1:0]     w_keep;
  logic [8*N-1:0]   w_masked;
  logic             w_out_free;

  // Occupancy counts the byte whose read has been issued but not yet landed,
  // so that reads stop exactly when the accumulator is spoken for.
  assign w_lvl = r_acc_cnt + CNT_W'(r_rd_pend);

  // Reads are gated by reset as well, so nothing is pulled from the FIFO
  // while the block is held in reset.
  assign rd_en = rst & (r_state == FILL) & ~r_flush_req & ~empty &
                 (w_lvl < CNT_W'(N));

  assign w_out_free = ~r_m_valid | m_ready;

  // Keep mask and zeroing of lanes that do not hold a gathered byte.
  always_comb begin
    w_keep   = '0;
    w_masked = '0;
    for (int k = 0; k < N; k++) begin
      w_keep[k]          = (CNT_W'(k) < r_acc_cnt);
      w_masked[8*k +: 8] = r_acc[8*k +: 8] & {8{w_keep[k]}};
    end
  end

  // Accumulator, FILL/EMIT control and the registered output port.
  // A transfer clears m_valid first; a reload in EMIT then overrides it so
  // back-to-back words can stream without a bubble.
  always_ff @(posedge clk_rd) begin
    if (!rst) begin
      r_state     <= FILL;
      r_acc_cnt   <= '0;
      r_rd_pend   <= 1'b0;
      r_flush_req <= 1'b0;
      r_acc       <= '0;
      r_m_valid   <= 1'b0;
      r_m_data    <= '0;
      r_m_keep    <= '0;
    end else begin
      r_rd_pend <= rd_en;

      if (r_m_valid && m_ready) begin
        r_m_valid <= 1'b0;
      end

      case (r_state)
        FILL: begin
          if (r_rd_pend) begin
            for (int k = 0; k < N; k++) begin
              if (r_acc_cnt == CNT_W'(k)) begin
                r_acc[8*k +: 8] <= rd_data;
              end
            end
            r_acc_cnt <= r_acc_cnt + CNT_W'(1);
          end

          // w_lvl equals the count after this cycle's capture.
          if (w_lvl == CNT_W'(N)) begin
            r_state <= EMIT;
          end else if (r_flush_req && !r_rd_pend) begin
            if (r_acc_cnt != '0) begin
              r_state <= EMIT;
            end else begin
              r_flush_req <= 1'b0;
            end
          end

          if (flush) begin
            r_flush_req <= 1'b1;
          end
        end

        EMIT: begin
          if (flush) begin
            r_flush_req <= 1'b1;
          end
          if (w_out_free) begin
            r_m_data    <= w_masked;
            r_m_keep    <= w_keep;
            r_m_valid   <= 1'b1;
            r_acc       <= '0;
            r_acc_cnt   <= '0;
            r_flush_req <= 1'b0;
            r_state     <= FILL;
          end
        end

        default: begin
          r_state <= FILL;
        end
      endcase
    end
  end

  assign m_valid = r_m_valid;
  assign m_data  = r_m_data;
  assign m_keep  = r_m_keep;
  assign lvl     = w_lvl;

endmodule
